// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares a single-port instruction memory between the fetch
// unit (read-only) and the loader/debug port (read/write). The loader has fixed
// priority, bounded by a MAX_BURST starvation limit. l_lock gives the loader
// exclusive ownership.
// Optional feature macro: IMEM_ARB_PERF_EN adds the conflict_cnt port and counter.
// rst is active-low and asserts asynchronously. Its release is expected to be
// synchronous to clk.
module imem_port_arbiter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    // fetch port
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    // loader port
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic          l_rvalid,
    output logic [DW-1:0] l_rdata,
    // memory side
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_data_in,
    output logic          mem_wr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_data_out
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [15:0]   conflict_cnt
`endif
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
    logic            f_rvalid_q, f_rvalid_d;
    logic [DW-1:0]   f_rdata_q, f_rdata_d;
    logic            l_rvalid_q, l_rvalid_d;
    logic [DW-1:0]   l_rdata_q, l_rdata_d;

    logic            burst_full;
    logic            fetch_blocked;

    // Grant decision. The loader wins unless the fetch has waited MAX_BURST
    // contended cycles and no lock is held. No grant is issued while in reset.
    always_comb begin
        f_gnt         = 1'b0;
        l_gnt         = 1'b0;
        burst_full    = (burst_cnt_q == BW'(MAX_BURST));
        // A held lock excludes fetch. The S_LOCK term keeps the loader on while
        // the burst budget remains, which matches plain loader priority.
        fetch_blocked = l_req && (l_lock || ((state_q == S_LOCK) && !burst_full));
        if (rst) begin
            if (l_req && (fetch_blocked || !f_req || !burst_full)) begin
                l_gnt = 1'b1;
            end else if (f_req) begin
                f_gnt = 1'b1;
            end
        end
    end

    // Memory drive from the current owner. Idle cycles drive zeros.
    always_comb begin
        mem_addr    = '0;
        mem_data_in = '0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        if (f_gnt) begin
            mem_addr = f_addr;
            mem_rd   = 1'b1;
        end else if (l_gnt) begin
            mem_addr    = l_addr;
            mem_data_in = l_wdata;
            mem_wr      = l_we;
            mem_rd      = !l_we;
        end
    end

    // Next owner state, starvation counter and read-return capture.
    always_comb begin
        state_d     = S_IDLE;
        burst_cnt_d = burst_cnt_q;
        f_rvalid_d  = 1'b0;
        f_rdata_d   = f_rdata_q;
        l_rvalid_d  = 1'b0;
        l_rdata_d   = l_rdata_q;

        if (f_gnt) begin
            state_d = S_FETCH;
        end else if (l_gnt && l_lock) begin
            state_d = S_LOCK;
        end else if (l_gnt) begin
            state_d = S_LOAD;
        end

        // The count also runs during a lock, so the first contended cycle
        // after a long lock goes to fetch.
        if (!f_req || f_gnt) begin
            burst_cnt_d = '0;
        end else if (l_gnt && !burst_full) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
        end

        if (f_gnt) begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = mem_data_out;
        end
        if (l_gnt && !l_we) begin
            l_rvalid_d = 1'b1;
            l_rdata_d  = mem_data_out;
        end
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            f_rvalid_q  <= 1'b0;
            f_rdata_q   <= '0;
            l_rvalid_q  <= 1'b0;
            l_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            f_rvalid_q  <= f_rvalid_d;
            f_rdata_q   <= f_rdata_d;
            l_rvalid_q  <= l_rvalid_d;
            l_rdata_q   <= l_rdata_d;
        end
    end

    assign f_rvalid = f_rvalid_q;
    assign f_rdata  = f_rdata_q;
    assign l_rvalid = l_rvalid_q;
    assign l_rdata  = l_rdata_q;

`ifdef IMEM_ARB_PERF_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    // Saturating count of cycles where both ports request.
    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (f_req && l_req && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Contention counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed stimulus with a read-return scoreboard.
// Set IMEM_ARB_PERF_EN to also exercise conflict_cnt.
module tb_imem_port_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          f_req, l_req, l_we, l_lock;
    logic [AW-1:0] f_addr, l_addr;
    logic [DW-1:0] l_wdata;
    logic          f_gnt, f_rvalid, l_gnt, l_rvalid;
    logic [DW-1:0] f_rdata, l_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in, mem_data_out;
    logic          mem_wr, mem_rd;
`ifdef IMEM_ARB_PERF_EN
    logic [15:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    imem_port_arbiter #(.DW(DW), .AW(AW), .MAX_BURST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .f_req        (f_req),
        .f_addr       (f_addr),
        .f_gnt        (f_gnt),
        .f_rvalid     (f_rvalid),
        .f_rdata      (f_rdata),
        .l_req        (l_req),
        .l_we         (l_we),
        .l_lock       (l_lock),
        .l_addr       (l_addr),
        .l_wdata      (l_wdata),
        .l_gnt        (l_gnt),
        .l_rvalid     (l_rvalid),
        .l_rdata      (l_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_data_out (mem_data_out)
`ifdef IMEM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Instruction memory model: combinational read, write on the clock edge.
    logic [DW-1:0] mem [32];
    assign mem_data_out = mem[mem_addr];
    always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_data_in;

    typedef struct packed {
        logic          is_l;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input logic is_l, input logic [DW-1:0] data);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid: port_l=%0b data=%h", is_l, data);
        end else begin
            e = exp_q.pop_front();
            if (e.is_l !== is_l || e.data !== data) begin
                n_fail++;
                $display("FAIL rdata: got port_l=%0b data=%h expected port_l=%0b data=%h",
                         is_l, data, e.is_l, e.data);
            end
        end
    endtask

    // Monitor: every read-return pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (f_rvalid) sb_pop(1'b0, f_rdata);
        if (l_rvalid) sb_pop(1'b1, l_rdata);
    end

    // owner: 0 none, 1 fetch, 2 loader. Read grants push exp_data.
    task automatic step(input string name, input logic fr, input logic [AW-1:0] fa,
                        input logic lr, input logic lw, input logic lk,
                        input logic [AW-1:0] la, input logic [DW-1:0] ld,
                        input int owner, input logic [DW-1:0] exp_data);
        logic [63:0] exp_v;
        @(negedge clk);
        f_req = fr; f_addr = fa; l_req = lr; l_we = lw; l_lock = lk;
        l_addr = la; l_wdata = ld;
        #2;
        // {f_gnt, l_gnt, mem_rd, mem_wr, mem_addr, mem_data_in}
        if (owner == 1) begin
            exp_v = 64'({4'b1010, fa, 32'h0});
            exp_q.push_back(exp_t'{1'b0, exp_data});
        end else if (owner == 2) begin
            exp_v = 64'({1'b0, 1'b1, ~lw, lw, la, ld});
            if (!lw) exp_q.push_back(exp_t'{1'b1, exp_data});
        end else begin
            exp_v = 64'h0;
        end
        chk(name, 64'({f_gnt, l_gnt, mem_rd, mem_wr, mem_addr, mem_data_in}), exp_v);
    endtask

    task automatic idle(input string name);
        step(name, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 0, '0);
    endtask

    string       owners;
    logic [3:0]  burst_pat;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        rst = 1'b0; f_req = 0; l_req = 0; l_we = 0; l_lock = 0;
        f_addr = '0; l_addr = '0; l_wdata = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({f_gnt, l_gnt, f_rvalid, l_rvalid, mem_rd, mem_wr, mem_addr}), 64'h0);
        chk("reset_rdata", 64'({f_rdata, l_rdata}), 64'h0);
        chk("reset_state", 64'(dut.state_q), 64'h0);
        rst = 1'b1;

        // Lone fetch read of address 3.
        step("t1_fetch", 1, 5'd3, 0, 0, 0, '0, '0, 1, 32'h1000_0003);
        idle("t1_idle");
        #2 chk("t1_rdata_hold", 64'(f_rdata), 64'h1000_0003);

        // Loader write, then fetch the written word; also a loader read.
        step("t2_lwrite", 0, '0, 1, 1, 0, 5'd7, 32'hDEADBEEF, 2, '0);
        step("t2_fetch7", 1, 5'd7, 0, 0, 0, '0, '0, 1, 32'hDEADBEEF);
        step("t2_lread5", 0, '0, 1, 0, 0, 5'd5, '0, 2, 32'h1000_0005);
        idle("t2_idle");

        // Contention with MAX_BURST=4: owners L,L,L,L,F,L,L,L,L,F.
        for (int i = 0; i < 10; i++) begin
            if (i == 4 || i == 9)
                step("t3_burst_f", 1, 5'd1, 1, 0, 0, 5'd2, '0, 1, 32'h1000_0001);
            else
                step("t3_burst_l", 1, 5'd1, 1, 0, 0, 5'd2, '0, 2, 32'h1000_0002);
        end
        idle("t3_idle");

        // Locked loader excludes fetch; the first contended cycle after release goes to fetch.
        for (int i = 0; i < 10; i++)
            step("t4_lock", 1, 5'd1, 1, 0, 1, 5'd4, '0, 2, 32'h1000_0004);
        #1 chk("t4_state_lock", 64'(dut.state_q), 64'd3);
        step("t4_release", 1, 5'd1, 1, 0, 0, 5'd4, '0, 1, 32'h1000_0001);
        step("t4_after", 0, '0, 1, 0, 0, 5'd4, '0, 2, 32'h1000_0004);
        idle("t4_idle");
        repeat (2) @(negedge clk);
        chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted between a fetch grant and its edge drops the access.
        @(negedge clk);
        f_req = 1; f_addr = 5'd2;
        #2 chk("t5_gnt", 64'({f_gnt, mem_rd, mem_addr}), 64'({2'b11, 5'd2}));
        #1 rst = 1'b0;
        #1 chk("t5_strobes", 64'({f_gnt, l_gnt, mem_rd, mem_wr, mem_addr}), 64'h0);
        @(posedge clk);
        #1 chk("t5_rvalid", 64'({f_rvalid, l_rvalid}), 64'h0);
        chk("t5_state", 64'(dut.state_q), 64'd0);
        @(negedge clk);
        f_req = 0; rst = 1'b1;

        // Ten contended cycles after reset: the arbitration pattern restarts.
        for (int i = 0; i < 10; i++) begin
            burst_pat = 4'(i);
            if (burst_pat == 4 || burst_pat == 9)
                step("t6_burst_f", 1, 5'd6, 1, 0, 0, 5'd8, '0, 1, 32'h1000_0006);
            else
                step("t6_burst_l", 1, 5'd6, 1, 0, 0, 5'd8, '0, 2, 32'h1000_0008);
        end
`ifdef IMEM_ARB_PERF_EN
        @(negedge clk);
        f_req = 0; l_req = 0;
        chk("t6_conflict10", 64'(conflict_cnt), 64'd10);
        @(negedge clk);
        chk("t6_conflict_hold", 64'(conflict_cnt), 64'd10);
`endif
        idle("t6_idle");
        repeat (3) @(negedge clk);
        #1 chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
